// File: rtl/dc_sweep_sequencer.sv
// dc_sweep_sequencer
//   Runs a nested DC sweep: outer loop steps the gate DAC (Vgs), inner loop
//   steps the drain DAC (Vds). At every point it waits a programmable settle
//   time, requests one ADC conversion of the probe current, converts it to
//   drain current (Id = -I_probe, saturating) and emits one record.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   start, abort            one-cycle control pulses
//   vgs_start/vgs_step      outer sweep start code and step
//   vds_start/vds_step      inner sweep start code and step
//   vgs_n/vds_n             points per axis (0 behaves as 1)
//   settle                  settle cycles after each setpoint change
//   vgs_code/vds_code       DAC setpoints
//   adc_req/adc_valid/adc_data   conversion request, sample strobe, sample
//   rec_valid/rec_ready     record handshake
//   rec_vgs_idx/rec_vds_idx/rec_id   record payload
//   busy, done              sweep active, completion/abort pulse
//   dbg_state               current FSM state, for observation only
//
// Handshakes: a record transfers on the rising edge where rec_valid and
// rec_ready are both high; while rec_valid is high and rec_ready is low the
// payload holds. adc_req stays high until the cycle adc_valid is seen.
module dc_sweep_sequencer #(
    parameter int DAC_W = 12,
    parameter int ADC_W = 16,
    parameter int IDX_W = 8,
    parameter int SET_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [DAC_W-1:0] vgs_start,
    input  logic [DAC_W-1:0] vgs_step,
    input  logic [DAC_W-1:0] vds_start,
    input  logic [DAC_W-1:0] vds_step,
    input  logic [IDX_W-1:0] vgs_n,
    input  logic [IDX_W-1:0] vds_n,
    input  logic [SET_W-1:0] settle,
    output logic [DAC_W-1:0] vgs_code,
    output logic [DAC_W-1:0] vds_code,
    output logic             adc_req,
    input  logic             adc_valid,
    input  logic [ADC_W-1:0] adc_data,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [IDX_W-1:0] rec_vgs_idx,
    output logic [IDX_W-1:0] rec_vds_idx,
    output logic [ADC_W-1:0] rec_id,
    output logic             busy,
    output logic             done,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SET     = 3'd1,
        SETTLE  = 3'd2,
        CONVERT = 3'd3,
        EMIT    = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [ADC_W-1:0] ADC_MIN = {1'b1, {(ADC_W-1){1'b0}}};
    localparam logic [ADC_W-1:0] ADC_MAX = {1'b0, {(ADC_W-1){1'b1}}};

    state_t state_q, state_d;

    // Latched sweep configuration
    logic [DAC_W-1:0] vgs_start_q, vgs_step_q, vds_start_q, vds_step_q;
    logic [IDX_W-1:0] vgs_last_q, vds_last_q;
    logic [SET_W-1:0] settle_q;
    logic             cfg_load;

    logic [SET_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] i_q, i_d, j_q, j_d;
    logic [DAC_W-1:0] vgs_code_q, vgs_code_d, vds_code_q, vds_code_d;
    logic [ADC_W-1:0] rec_id_q, rec_id_d;
    logic [ADC_W-1:0] id_neg;
    logic             sweep_active;

    // Negating the most negative sample would overflow; clamp it instead.
    assign id_neg = (adc_data == ADC_MIN) ? ADC_MAX : (~adc_data + ADC_W'(1));

    assign sweep_active = (state_q == SET) || (state_q == SETTLE) ||
                          (state_q == CONVERT) || (state_q == EMIT);
    assign cfg_load     = (state_q == IDLE) && start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vgs_start_q <= '0;
            vgs_step_q  <= '0;
            vds_start_q <= '0;
            vds_step_q  <= '0;
            vgs_last_q  <= '0;
            vds_last_q  <= '0;
            settle_q    <= '0;
        end else if (cfg_load) begin
            vgs_start_q <= vgs_start;
            vgs_step_q  <= vgs_step;
            vds_start_q <= vds_start;
            vds_step_q  <= vds_step;
            // A count of 0 sweeps a single point, same as a count of 1.
            vgs_last_q  <= (vgs_n == '0) ? '0 : vgs_n - IDX_W'(1);
            vds_last_q  <= (vds_n == '0) ? '0 : vds_n - IDX_W'(1);
            settle_q    <= settle;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            i_q        <= '0;
            j_q        <= '0;
            vgs_code_q <= '0;
            vds_code_q <= '0;
            rec_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            i_q        <= i_d;
            j_q        <= j_d;
            vgs_code_q <= vgs_code_d;
            vds_code_q <= vds_code_d;
            rec_id_q   <= rec_id_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        i_d        = i_q;
        j_d        = j_q;
        vgs_code_d = vgs_code_q;
        vds_code_d = vds_code_q;
        rec_id_d   = rec_id_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    i_d        = '0;
                    j_d        = '0;
                    vgs_code_d = vgs_start;
                    vds_code_d = vds_start;
                    state_d    = SET;
                end
            end
            SET: begin
                // Counter is preloaded with settle-1 so SETTLE lasts exactly
                // settle cycles; settle=0 skips SETTLE altogether.
                cnt_d   = settle_q - SET_W'(1);
                state_d = (settle_q == '0) ? CONVERT : SETTLE;
            end
            SETTLE: begin
                if (cnt_q == '0) state_d = CONVERT;
                else             cnt_d   = cnt_q - SET_W'(1);
            end
            CONVERT: begin
                if (adc_valid) begin
                    rec_id_d = id_neg;
                    state_d  = EMIT;
                end
            end
            EMIT: begin
                if (rec_ready) begin
                    if (j_q < vds_last_q) begin
                        j_d        = j_q + IDX_W'(1);
                        vds_code_d = vds_code_q + vds_step_q;
                        state_d    = SET;
                    end else if (i_q < vgs_last_q) begin
                        j_d        = '0;
                        vds_code_d = vds_start_q;
                        i_d        = i_q + IDX_W'(1);
                        vgs_code_d = vgs_code_q + vgs_step_q;
                        state_d    = SET;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort && sweep_active) begin
            state_d = DONE;
        end

        // Entering DONE parks the DACs at 0 and clears the point indices.
        if (state_d == DONE) begin
            vgs_code_d = '0;
            vds_code_d = '0;
            i_d        = '0;
            j_d        = '0;
        end
    end

    // abort drops the request/valid in the same cycle it is seen.
    assign adc_req     = (state_q == CONVERT) && !abort;
    assign rec_valid   = (state_q == EMIT) && !abort;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign vgs_code    = vgs_code_q;
    assign vds_code    = vds_code_q;
    assign rec_vgs_idx = i_q;
    assign rec_vds_idx = j_q;
    assign rec_id      = rec_id_q;
    assign dbg_state   = state_q;

endmodule
